interrupt_arbiter: RTL

Priority arbiter and claim/complete sequencer for the 48 external interrupt lines. It sits between the registered `interrupt_pending` vector produced by the interrupt receive stage and the CPU trap interface. It selects the highest-priority eligible source and presents its ID to the core. On acceptance it returns an ack/ID pair to the receive stage and tracks the handler until end-of-interrupt. Only one interrupt is outstanding at a time; there is no nesting.

---
 rtl/interrupt_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/interrupt_arbiter.sv
// Priority arbiter and claim/complete sequencer for the external interrupt lines.
// Picks the highest-priority eligible source, requests the CPU, and tracks one handler at a time.
module interrupt_arbiter #(
  parameter int NUM_SRC = 48,
  parameter int ID_BASE = 16
) (
  input  logic                   zic_clk,
  input  logic                   zic_rst,
  input  logic                   wdt_reset_i,
  input  logic [NUM_SRC-1:0]     pending_i,
  input  logic                   pending_valid_i,
  input  logic [2*NUM_SRC-1:0]   priority_i,
  input  logic [1:0]             threshold_i,
  input  logic                   global_en_i,
  output logic                   irq_req_o,
  output logic [7:0]             irq_id_o,
  input  logic                   irq_ack_i,
  input  logic                   irq_done_i,
  output logic                   ack_o,
  output logic [7:0]             ack_id_o,
  output logic                   active_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE, HOLDOFF} state_t;

  state_t             state, next_state;
  logic [IDX_W-1:0]   src_q, src_d;
  logic               hold_cnt, hold_cnt_d;

  logic [NUM_SRC-1:0] eligible;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [1:0]         win_prio;
  logic [7:0]         win_id;
  logic               src_eligible;

  logic               req_d, ack_d, active_d;
  logic [7:0]         id_d, ack_id_d;

  // Ascending scan with a strict compare keeps the lowest index on priority ties.
  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    eligible  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      eligible[n] = pending_valid_i & global_en_i & pending_i[n] &
                    (priority_i[2*n +: 2] > threshold_i);
      if (eligible[n] && (!win_found || (priority_i[2*n +: 2] > win_prio))) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(n);
        win_prio  = priority_i[2*n +: 2];
      end
    end
  end

  assign win_id       = 8'(ID_BASE) + 8'(win_idx);
  assign src_eligible = eligible[src_q];

  // State and registered outputs.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge zic_clk or negedge zic_rst) begin
    if (!zic_rst) begin
      state     <= IDLE;
      src_q     <= '0;
      hold_cnt  <= 1'b0;
      irq_req_o <= 1'b0;
      irq_id_o  <= '0;
      ack_o     <= 1'b0;
      ack_id_o  <= '0;
      active_o  <= 1'b0;
    end else begin
      state     <= next_state;
      src_q     <= src_d;
      hold_cnt  <= hold_cnt_d;
      irq_req_o <= req_d;
      irq_id_o  <= id_d;
      ack_o     <= ack_d;
      ack_id_o  <= ack_id_d;
      active_o  <= active_d;
    end
  end

  // Next-state logic; ack outranks withdrawal while requesting.
  always_comb begin
    next_state = state;
    if (wdt_reset_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (win_found) next_state = REQ;
        REQ: begin
          if (irq_ack_i)          next_state = SERVICE;
          else if (!src_eligible) next_state = IDLE;
        end
        SERVICE: if (irq_done_i) next_state = HOLDOFF;
        HOLDOFF: if (hold_cnt)   next_state = IDLE;
        default:                 next_state = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the transition being taken.
  always_comb begin
    req_d      = (next_state == REQ);
    active_d   = (next_state == SERVICE);
    ack_d      = (state == REQ) && (next_state == SERVICE);
    hold_cnt_d = (state == HOLDOFF) && (next_state == HOLDOFF);
    src_d      = (state == IDLE) ? win_idx : src_q;

    if (next_state == IDLE)
      id_d = '0;
    else if (state == IDLE)
      id_d = win_id;
    else
      id_d = irq_id_o;

    if (ack_d)
      ack_id_d = irq_id_o;
    else if (wdt_reset_i)
      ack_id_d = '0;
    else
      ack_id_d = ack_id_o;
  end

endmodule
